// File: rtl/line_mem_responder.sv
// line_mem_responder: latency-accurate instruction line memory behind the icache refill port,
// with a 2-entry request queue and strictly in-order responses.
module line_mem_responder #(
  parameter int    NUM_LINES = 1024,
  parameter int    LATENCY   = 4,
  parameter string INIT_FILE = ""
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [31:0]  pc_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [31:0]  rsp_mem_addr_o,
  output logic [511:0] instr_line_o
);
  localparam int IW = $clog2(NUM_LINES);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  logic [511:0] mem [NUM_LINES];
  logic [31:0]  fifo_q [2];
  logic [31:0]  fifo_d [2];
  logic [1:0]   count_q;
  state_e       state_q;
  logic [CW-1:0] lat_q;
  logic [31:0]  act_q;
  logic [31:0]  addr_q;
  logic [31:0]  rd_addr;
  logic [511:0] line_q;
  logic         valid_q;
  logic         push;
  logic         pop;
  logic         load;

  assign req_ready_o    = count_q != 2'd2;
  assign rsp_valid_o    = valid_q;
  assign rsp_mem_addr_o = addr_q;
  assign instr_line_o   = line_q;

  // A pop only happens from IDLE or on response acceptance, so the head feeds the
  // array read whenever the FSM is not counting down an active request.
  always_comb begin
    push      = req_valid_i && req_ready_o;
    pop       = count_q != 2'd0 && (state_q == IDLE || (state_q == RESP && rsp_ready_i));
    load      = (pop && LATENCY == 1) || (state_q == WAIT && lat_q == CW'(1));
    rd_addr   = state_q == WAIT ? act_q : fifo_q[0];
    fifo_d[0] = pop && count_q == 2'd2 ? fifo_q[1] :
                push && (pop || count_q == 2'd0) ? pc_i & 32'hFFFF_FFC0 : fifo_q[0];
    fifo_d[1] = push && !pop && count_q == 2'd1 ? pc_i & 32'hFFFF_FFC0 : fifo_q[1];
  end

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      count_q   <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      count_q   <= count_q + 2'(push) - 2'(pop);
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
    end

  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state_q <= IDLE;
      lat_q   <= '0;
      act_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      if (pop) begin
        state_q <= LATENCY == 1 ? RESP : WAIT;
        act_q   <= fifo_q[0];
        lat_q   <= CW'(LATENCY - 1);
      end else if (state_q == WAIT) begin
        state_q <= lat_q == CW'(1) ? RESP : WAIT;
        lat_q   <= lat_q - CW'(1);
      end else if (state_q == RESP && rsp_ready_i)
        state_q <= IDLE;
      if (load) begin
        addr_q <= rd_addr;
        line_q <= mem[rd_addr[6 +: IW]];
      end
      valid_q <= load || (valid_q && !rsp_ready_i);
    end
endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: scoreboard bench driving a LATENCY=4 and a LATENCY=1 responder
// from shared stimulus; each instance has its own expected-response queue.
module tb_line_mem_responder;
  logic clk = 1'b0;
  logic rstn;
  logic req_valid;
  logic rsp_ready;
  logic [31:0] pc;
  logic rdy [2];
  logic v [2];
  logic [31:0] a [2];
  logic [511:0] l [2];
  logic [31:0] sb [2][$];
  logic hold [2] = '{1'b0, 1'b0};
  logic [31:0] pa [2];
  logic [511:0] pl [2];
  logic [31:0] e_m;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_mem_responder #(.NUM_LINES(1024), .LATENCY(4)) u4 (
    .clk_i(clk), .rstn_i(rstn), .req_valid_i(req_valid), .req_ready_o(rdy[0]), .pc_i(pc),
    .rsp_valid_o(v[0]), .rsp_ready_i(rsp_ready), .rsp_mem_addr_o(a[0]), .instr_line_o(l[0])
  );
  line_mem_responder #(.NUM_LINES(1024), .LATENCY(1)) u1 (
    .clk_i(clk), .rstn_i(rstn), .req_valid_i(req_valid), .req_ready_o(rdy[1]), .pc_i(pc),
    .rsp_valid_o(v[1]), .rsp_ready_i(rsp_ready), .rsp_mem_addr_o(a[1]), .instr_line_o(l[1])
  );

  function automatic logic [511:0] exp_line(input logic [31:0] p);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = {6'd0, p[15:6], 16'(i)};
    return r;
  endfunction

  task automatic chk(input string nm, input int d, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d] act=%0h exp=%0h", nm, d, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] p);
    int n = 0;
    req_valid = 1'b1;
    pc = p;
    while (!rdy[0] && n < 200) begin
      step();
      n++;
    end
    chk("send_timeout", 0, n < 200, 1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic lat_chk();
    for (int n = 1; n <= 5; n++) begin
      step();
      chk("lat4_valid", 0, v[0], n == 4);
      chk("lat1_valid", 1, v[1], n == 1);
    end
  endtask

  always @(negedge clk)
    for (int d = 0; d < 2; d++)
      if (!rstn) begin
        sb[d].delete();
        hold[d] = 1'b0;
      end else begin
        if (req_valid && rdy[d]) sb[d].push_back(pc & 32'hFFFF_FFC0);
        if (hold[d]) begin
          chk("stable_valid", d, v[d], 1);
          chk("stable_addr", d, a[d], pa[d]);
          chk("stable_line", d, l[d], pl[d]);
        end
        if (v[d] && rsp_ready) begin
          if (sb[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_rsp[dut%0d] act=%0h exp=none", d, a[d]);
          end else begin
            e_m = sb[d].pop_front();
            chk("rsp_addr", d, a[d], e_m);
            chk("rsp_line", d, l[d], exp_line(e_m));
          end
        end
        hold[d] = v[d] && !rsp_ready;
        pa[d] = a[d];
        pl[d] = l[d];
      end

  initial begin
    int n;
    logic [31:0] t4a [5];
    logic t4v [5];
    t4v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    t4a = '{32'h0, 32'h0, 32'h40, 32'h80, 32'h0};
    for (int k = 0; k < 1024; k++)
      for (int i = 0; i < 16; i++) begin
        u4.mem[k][32*i +: 32] = {k[15:0], i[15:0]};
        u1.mem[k][32*i +: 32] = {k[15:0], i[15:0]};
      end
    rstn = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    pc = '0;
    step(3);
    rstn = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", d, rdy[d], 1);
      chk("rst_valid", d, v[d], 0);
      chk("rst_addr", d, a[d], 0);
      chk("rst_line", d, l[d], 0);
    end
    // single request: latency, data layout, one-cycle pulse
    req_valid = 1'b1;
    pc = 32'h0000_0048;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("lat4_valid", 0, v[0], k == 4);
      chk("lat1_valid", 1, v[1], k == 1);
      if (k == 4) begin
        chk("t1_addr", 0, a[0], 32'h0000_0040);
        chk("t1_word0", 0, l[0][31:0], 32'h0001_0000);
        chk("t1_word15", 0, l[0][511:480], 32'h0001_000F);
      end
    end
    step(4);
    // backpressure: queue fills, first response held, then drained in order
    rsp_ready = 1'b0;
    send(32'h000);
    send(32'h040);
    send(32'h080);
    req_valid = 1'b1;
    pc = 32'h0C0;
    step(14);
    chk("full_ready", 0, rdy[0], 0);
    chk("held_valid", 0, v[0], 1);
    chk("held_addr", 0, a[0], 32'h000);
    rsp_ready = 1'b1;
    n = 0;
    while (!rdy[0] && n < 50) begin
      step();
      n++;
    end
    chk("release_timeout", 0, n < 50, 1);
    step();
    req_valid = 1'b0;
    step(30);
    // alias: upper address bits ignored for indexing, kept in the tag
    send(32'h0001_0004);
    n = 0;
    while (!v[0] && n < 50) begin
      step();
      n++;
    end
    chk("alias_timeout", 0, n < 50, 1);
    chk("alias_addr", 0, a[0], 32'h0001_0000);
    chk("alias_word1", 0, l[0][63:32], 32'h0000_0001);
    step(6);
    // LATENCY=1 streaming: one response per cycle after the first
    pc = 32'h0;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      pc = pc + 32'h40;
      if (k >= 2) req_valid = 1'b0;
      chk("stream_valid", 1, v[1], t4v[k]);
      if (t4v[k]) chk("stream_addr", 1, a[1], t4a[k]);
    end
    step(20);
    // reset while waiting with one queued entry
    send(32'h100);
    send(32'h140);
    step();
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("post_rst_valid", d, v[d], 0);
      chk("post_rst_ready", d, rdy[d], 1);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      chk("no_stale", 0, v[0], 0);
    end
    send(32'h1C0);
    lat_chk();
    step(4);
    // random valid/ready traffic
    for (int k = 0; k < 2000; k++) begin
      req_valid = 1'($urandom_range(0, 1));
      pc = $urandom;
      rsp_ready = $urandom_range(0, 3) != 0;
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step(40);
    for (int d = 0; d < 2; d++) chk("drain", d, sb[d].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
